// File: rtl/product_bcd_converter_pkg.sv
// Shared definitions for the Booth multiplier datapath and its BCD output stage.
package product_bcd_converter_pkg;

    localparam int unsigned PRODUCT_WIDTH     = 16;
    localparam int unsigned BCD_DIGITS        = 5;
    localparam int unsigned BCD_ADJ_THRESHOLD = 5;
    localparam int unsigned BCD_ADJ_VALUE     = 3;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

endpackage

// File: rtl/product_bcd_converter_bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adjust
    import product_bcd_converter_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        if (digit_in >= 4'(BCD_ADJ_THRESHOLD)) begin
            digit_out = digit_in + 4'(BCD_ADJ_VALUE);
        end else begin
            digit_out = digit_in;
        end
    end

endmodule

// File: rtl/product_bcd_converter.sv
// Signed product to sign + packed BCD, one double-dabble shift per cycle.
// Optional BCD_LEADING_ZERO_BLANK_EN adds a leading-zero blanking mask output.
module product_bcd_converter
    import product_bcd_converter_pkg::*;
#(
    parameter int unsigned WIDTH  = PRODUCT_WIDTH,
    parameter int unsigned DIGITS = BCD_DIGITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      product,
    output logic                  busy,
    output logic                  done,
    output logic                  sign,
    output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_LEADING_ZERO_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t            state;
    logic [WIDTH-1:0]  mag;
    logic [BW-1:0]     acc;
    logic [BW-1:0]     acc_adj;
    logic [BW-1:0]     acc_next;
    logic [CW-1:0]     cnt;
    logic              sign_pend;
    logic [WIDTH:0]    prod_ext;
    logic [WIDTH:0]    prod_abs;
    logic [BW+WIDTH-1:0] sr_next;

    // One extra bit so the most negative product has a representable magnitude.
    always_comb begin
        prod_ext = {product[WIDTH-1], product};
        prod_abs = product[WIDTH-1] ? (~prod_ext + {{WIDTH{1'b0}}, 1'b1}) : prod_ext;
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_in  (acc[4*i +: 4]),
            .digit_out (acc_adj[4*i +: 4])
        );
    end

    always_comb begin
        sr_next  = {acc_adj, mag} << 1;
        acc_next = sr_next[BW+WIDTH-1 -: BW];
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_next;

    always_comb begin
        blank_next = '0;
        blank_next[DIGITS-1] = (acc_next[BW-1 -: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 1; i--) begin
            blank_next[i] = blank_next[i+1] & (acc_next[4*i +: 4] == 4'd0);
        end
        blank_next[0] = 1'b0;
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sign      <= 1'b0;
            bcd       <= '0;
            mag       <= '0;
            acc       <= '0;
            cnt       <= '0;
            sign_pend <= 1'b0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
            blank     <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Zero magnitude never reports as negative.
                        sign_pend <= product[WIDTH-1] & (prod_abs != '0);
                        mag       <= prod_abs[WIDTH-1:0];
                        acc       <= '0;
                        cnt       <= CW'(WIDTH);
                        busy      <= 1'b1;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    acc <= acc_next;
                    mag <= sr_next[WIDTH-1:0];
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bcd   <= acc_next;
                        sign  <= sign_pend;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
`ifdef BCD_LEADING_ZERO_BLANK_EN
                        blank <= blank_next;
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed-vector bench for product_bcd_converter (with or without leading-zero blanking).
module tb_product_bcd_converter;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] product;
    logic        busy;
    logic        done;
    logic        sign;
    logic [19:0] bcd;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [4:0]  blank;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] product;
        logic        sign;
        logic [19:0] bcd;
        logic [4:0]  blank;
    } vec_t;

    vec_t vecs[12];

    product_bcd_converter dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .product (product),
        .busy    (busy),
        .done    (done),
        .sign    (sign),
        .bcd     (bcd)
`ifdef BCD_LEADING_ZERO_BLANK_EN
        ,
        .blank   (blank)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input logic [15:0] p, input logic es, input logic [19:0] eb,
                       input logic [4:0] ebl, input logic [19:0] prev_bcd, input logic prev_sign);
        int edges;
        int busy_cnt;
        bit held;
        start   = 1'b1;
        product = p;
        step();
        start    = 1'b0;
        product  = ~p;
        busy_cnt = busy ? 1 : 0;
        held     = (bcd === prev_bcd) && (sign === prev_sign);
        edges    = 0;
        while (!done && edges < 40) begin
            step();
            edges++;
            if (busy) busy_cnt++;
            if (!done && (bcd !== prev_bcd || sign !== prev_sign)) held = 0;
        end
        check($sformatf("latency %h", p), edges, 16);
        check($sformatf("busy_cycles %h", p), busy_cnt, 16);
        check($sformatf("hold %h", p), 32'(held), 1);
        check($sformatf("sign %h", p), 32'(sign), 32'(es));
        check($sformatf("bcd %h", p), 32'(bcd), 32'(eb));
`ifdef BCD_LEADING_ZERO_BLANK_EN
        check($sformatf("blank %h", p), 32'(blank), 32'(ebl));
`else
        if (ebl === 5'bxxxxx) n_vec += 0;
`endif
        step();
        check($sformatf("done_pulse %h", p), {30'd0, done, busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int   edges;
        bit   held;
        logic [19:0] prev_bcd;
        logic        prev_sign;

        vecs[0]  = '{16'h4000, 1'b0, 20'h16384, 5'b00000};
        vecs[1]  = '{16'hC080, 1'b1, 20'h16256, 5'b00000};
        vecs[2]  = '{16'h0000, 1'b0, 20'h00000, 5'b11110};
        vecs[3]  = '{16'hFFFF, 1'b1, 20'h00001, 5'b11110};
        vecs[4]  = '{16'h8000, 1'b1, 20'h32768, 5'b00000};
        vecs[5]  = '{16'h7FFF, 1'b0, 20'h32767, 5'b00000};
        vecs[6]  = '{16'h0019, 1'b0, 20'h00025, 5'b11100};
        vecs[7]  = '{16'h0064, 1'b0, 20'h00100, 5'b11000};
        vecs[8]  = '{16'h3039, 1'b0, 20'h12345, 5'b00000};
        vecs[9]  = '{16'hCFC7, 1'b1, 20'h12345, 5'b00000};
        vecs[10] = '{16'h0009, 1'b0, 20'h00009, 5'b11110};
        vecs[11] = '{16'hFC18, 1'b1, 20'h01000, 5'b10000};

        reset   = 1'b0;
        start   = 1'b0;
        product = 16'h0000;
        #12;
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset sign", 32'(sign), 0);
        check("reset bcd", 32'(bcd), 0);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        check("reset blank", 32'(blank), 32'(5'b11110));
`endif
        reset = 1'b1;
        step();

        prev_bcd  = 20'h0;
        prev_sign = 1'b0;
        for (int i = 0; i < 12; i++) begin
            run(vecs[i].product, vecs[i].sign, vecs[i].bcd, vecs[i].blank, prev_bcd, prev_sign);
            prev_bcd  = vecs[i].bcd;
            prev_sign = vecs[i].sign;
        end

        // Second start during CONV must be ignored and not queued.
        run(16'd25, 1'b0, 20'h00025, 5'b11100, prev_bcd, prev_sign);
        start   = 1'b1;
        product = 16'd99;
        step();
        edges = 0;
        held  = 1;
        while (!done && edges < 40) begin
            if (edges == 4) begin
                start   = 1'b1;
                product = 16'd7;
            end else begin
                start = 1'b0;
            end
            step();
            edges++;
            if (!done && bcd !== 20'h00025) held = 0;
        end
        start = 1'b0;
        check("ignored_start latency", edges, 16);
        check("ignored_start hold", 32'(held), 1);
        check("ignored_start bcd", 32'(bcd), 32'(20'h00099));
        check("ignored_start sign", 32'(sign), 0);
        repeat (3) step();
        check("ignored_start not queued", 32'(busy), 0);

        // Asynchronous reset in the middle of a conversion.
        run(16'hFFFF, 1'b1, 20'h00001, 5'b11110, 20'h00099, 1'b0);
        start   = 1'b1;
        product = 16'd12345;
        step();
        start = 1'b0;
        repeat (7) step();
        check("pre_reset busy", 32'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check("async_reset busy", 32'(busy), 0);
        check("async_reset done", 32'(done), 0);
        check("async_reset sign", 32'(sign), 0);
        check("async_reset bcd", 32'(bcd), 0);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        check("async_reset blank", 32'(blank), 32'(5'b11110));
`endif
        step();
        reset = 1'b1;
        step();
        check("post_reset idle", 32'(busy), 0);
        run(16'd12, 1'b0, 20'h00012, 5'b11100, 20'h00000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/product_bcd_converter.md
Name: product_bcd_converter

Overview:
- Downstream stage of the radix-4 Booth multiplier. Consumes the 16-bit signed product {acc, mplier[8:1]} when the multiplier controller finishes.
- Converts the product to sign + 5-digit packed BCD with an iterative double-dabble engine, one bit per cycle.
- Holds the result for the seven-segment/LED display driver on the breadboard.

Parameters:
- WIDTH, 16, product width in bits (two's complement)
- DIGITS, 5, BCD digits produced; must satisfy 10^DIGITS > 2^(WIDTH-1)

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); deasserts synchronously to clock
- start  input  1  level sampled in IDLE; high requests conversion of product
- product  input  WIDTH  signed product, sampled on the same edge as start
- busy  output  1  high while a conversion is in progress (CONV state)
- done  output  1  one-cycle pulse; bcd/sign valid and updated in that cycle
- sign  output  1  1 = product was negative
- bcd  output  4*DIGITS  packed BCD magnitude, digit 0 in [3:0]

Behaviour:
- Reset (reset=0, any time, mid-conversion included): state IDLE, busy=0, done=0, sign=0, bcd=0, shift register and bit counter cleared. Takes effect immediately, without waiting for a clock edge.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - start=1 at a rising edge → capture sign=product[WIDTH-1] into an internal pending-sign register.
  - Magnitude = |product| computed at WIDTH+1 bits, so -2^(WIDTH-1) gives 2^(WIDTH-1) with no overflow.
  - Load the BCD accumulator with 0 and the counter with WIDTH; go to CONV.
- CONV, each edge:
  - Every BCD digit >= 5 gets +3 (combinational).
  - Shift {bcd_acc, mag} left by 1; decrement counter.
  - The edge that performs shift number WIDTH also:
    - loads output bcd with the post-shift accumulator;
    - loads output sign with the pending sign, forced to 0 when magnitude = 0;
    - sets done=1 and moves to DONE.
- DONE: lasts one cycle; done=1, busy=0. Next edge: done=0, go to IDLE.
- Latency: counting the start-sampling edge as edge 0, done and the new bcd/sign are visible after edge WIDTH (16). busy is high after edges 0..WIDTH-1.
- Throughput: at most one conversion per WIDTH+2 cycles.
- start in CONV or DONE is ignored; the request is not queued. If start is still high when the FSM returns to IDLE, a new conversion begins on the next edge.
- product changes after the sampling edge have no effect on the conversion in progress.
- bcd/sign hold their last value between done pulses, including while a new conversion is busy. The display never shows partial results.
- Each digit in bcd is always in 0..9.

Optional Feature:
- Macro BCD_LEADING_ZERO_BLANK_EN.
- Defined:
  - Adds output blank, width DIGITS, registered and updated with bcd.
  - blank[i]=1 when digit i and all higher digits are 0, for i>=1.
  - blank[0] is always 0, so zero displays as a single 0.
  - Reset value is all 1s except bit 0.
- Not defined: port blank absent; no other behaviour changes.

Decomposition:
- Shared package (alongside the multiplier definitions):
  - state enum {IDLE, CONV, DONE};
  - PRODUCT_WIDTH=16;
  - BCD_DIGITS=5;
  - BCD_ADJ_THRESHOLD=5;
  - BCD_ADJ_VALUE=3.
- One sub-module, bcd_digit_adjust: 4-bit in, 4-bit out, adds 3 when input >= 5. Instantiated DIGITS times in a generate loop.
- Counter, FSM and shift register stay in the top module.

Test Plan:
- product=16'h4000 (16384), start pulse → done exactly after edge 16; sign=0, bcd=20'h16384; busy high for 16 cycles.
- product=16'hC080 (-16256) → sign=1, bcd=20'h16256. With BCD_LEADING_ZERO_BLANK_EN: blank=5'b00000.
- product=16'h0000 → sign=0, bcd=20'h00000. With macro: blank=5'b11110. Then product=16'hFFFF (-1) → sign=1, bcd=20'h00001.
- product=16'h8000 → sign=1, bcd=20'h32768 (boundary, no overflow). product=16'h7FFF → sign=0, bcd=20'h32767.
- Convert 25 (bcd=20'h00025). Start a conversion of 99, then pulse start again at cycle 5 with product=7 → second start ignored; result 20'h00099. bcd holds 20'h00025 until that done.
- Drive reset=0 asynchronously mid-CONV (cycle 8) → busy, done, sign, bcd clear immediately. After release, start with 12 → bcd=20'h00012 after 16 edges.
